dpwm_duty_ctrl: RTL and testbench

DPWM_DUTY_CTRL -- requirements
Module: dpwm_duty_ctrl

---
 rtl/dpwm_pkg.sv | 13 +
 rtl/dpwm_contador.sv | 25 ++
 rtl/dpwm_duty_ctrl.sv | 80 ++++++++
 tb/tb_dpwm_duty_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpwm_pkg.sv
// Shared defaults for the DPWM duty controller: geometry, step sizes, reset duty
// and the bit positions of the inc/dec pulses on dato.
package dpwm_pkg;

    localparam int DPWM_WIDTH       = 8;
    localparam int DPWM_STEP_FINE   = 1;
    localparam int DPWM_STEP_COARSE = 16;
    localparam int DPWM_DUTY_RST    = 128;

    localparam int INC = 0;
    localparam int DEC = 1;

endpackage

// File: rtl/dpwm_contador.sv
// Free-running period counter for the DPWM, with a terminal-count flag that marks
// the last cycle of each period.
module dpwm_contador
    import dpwm_pkg::*;
#(
    parameter int WIDTH = DPWM_WIDTH
) (
    input  logic             clkm,
    input  logic             reset,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == {WIDTH{1'b1}});

endmodule

// File: rtl/dpwm_duty_ctrl.sv
// DPWM with a pending duty register adjusted by inc/dec pulses (saturating) and an
// active duty that is only reloaded at period boundaries, so each period is glitch-free.
module dpwm_duty_ctrl
    import dpwm_pkg::*;
#(
    parameter int WIDTH       = DPWM_WIDTH,
    parameter int STEP_FINE   = DPWM_STEP_FINE,
    parameter int STEP_COARSE = DPWM_STEP_COARSE,
    parameter int DUTY_RST    = DPWM_DUTY_RST
) (
    input  logic             clkm,
    input  logic             reset,
    input  logic [1:0]       dato,
    input  logic             sel,
    output logic             pwm_out,
    output logic [WIDTH-1:0] duty_out,
    output logic             sat_hi,
    output logic             sat_lo,
    output logic             upd
);

    localparam logic [WIDTH:0]   STEP_F     = (WIDTH+1)'(STEP_FINE);
    localparam logic [WIDTH:0]   STEP_C     = (WIDTH+1)'(STEP_COARSE);
    localparam logic [WIDTH-1:0] DUTY_INIT  = WIDTH'(DUTY_RST);

    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] duty_d;
    logic [WIDTH-1:0] act_q;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    dpwm_contador #(
        .WIDTH (WIDTH)
    ) u_contador (
        .clkm  (clkm),
        .reset (reset),
        .cnt   (cnt),
        .tc    (tc)
    );

    // The extra MSB of sum/diff is the overflow/borrow that drives saturation.
    always_comb begin
        // NOTE: default assignment first so no path leaves duty_d unassigned (no latch).
        duty_d = duty_q;
        step   = sel ? STEP_C : STEP_F;
        sum    = {1'b0, duty_q} + step;
        diff   = {1'b0, duty_q} - step;
        if (dato[INC] && !dato[DEC]) begin
            duty_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end else if (dato[DEC] && !dato[INC]) begin
            duty_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        end
    end

    // act_q captures the pre-edge pending value on the terminal count, so a pulse in
    // that same cycle is deferred to the next boundary.
    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            duty_q  <= DUTY_INIT;
            act_q   <= DUTY_INIT;
            pwm_out <= 1'b0;
            upd     <= 1'b0;
        end else begin
            duty_q  <= duty_d;
            pwm_out <= (cnt < act_q);
            upd     <= tc && (duty_q != act_q);
            if (tc) begin
                act_q <= duty_q;
            end
        end
    end

    assign duty_out = duty_q;
    assign sat_hi   = &duty_q;
    assign sat_lo   = ~|duty_q;

endmodule

// File: tb/tb_dpwm_duty_ctrl.sv
// Self-checking bench for dpwm_duty_ctrl: a cycle model pushes expected outputs to a
// scoreboard queue as stimulus is driven; they are popped and compared after each edge.
module tb_dpwm_duty_ctrl;
    import dpwm_pkg::*;

    localparam int MAXV = 255;

    logic       clkm  = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dato  = 2'b00;
    logic       sel   = 1'b0;
    logic       pwm_out;
    logic [7:0] duty_out;
    logic       sat_hi;
    logic       sat_lo;
    logic       upd;

    always #5 clkm = ~clkm;

    dpwm_duty_ctrl #(
        .WIDTH       (8),
        .STEP_FINE   (1),
        .STEP_COARSE (16),
        .DUTY_RST    (128)
    ) dut (
        .clkm     (clkm),
        .reset    (reset),
        .dato     (dato),
        .sel      (sel),
        .pwm_out  (pwm_out),
        .duty_out (duty_out),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo),
        .upd      (upd)
    );

    typedef struct {
        int   duty;
        logic pwm;
        logic upd;
        logic hi;
        logic lo;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    // Model state: values the DUT holds just before the next rising edge.
    int   m_cnt, m_pend, m_act;
    int   acc, last_hi, upd_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input logic [1:0] d, input logic s);
        exp_t e;
        int   st, p, pre;
        @(negedge clkm);
        dato = d;
        sel  = s;
        st = s ? 16 : 1;
        p  = m_pend;
        if (d == 2'b01) p = m_pend + st;
        else if (d == 2'b10) p = m_pend - st;
        if (p > MAXV) p = MAXV;
        if (p < 0) p = 0;
        e.upd = (m_cnt == MAXV) && (m_pend != m_act);
        e.pwm = (m_cnt < m_act);
        if (m_cnt == MAXV) m_act = m_pend;
        m_pend = p;
        pre    = m_cnt;
        m_cnt  = (m_cnt + 1) % (MAXV + 1);
        e.duty = p;
        e.hi   = (p == MAXV);
        e.lo   = (p == 0);
        sb.push_back(e);

        @(posedge clkm);
        #1;
        dato = 2'b00;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("duty_out", duty_out, e.duty);
            check("pwm_out", pwm_out, e.pwm);
            check("upd", upd, e.upd);
            check("sat_hi", sat_hi, e.hi);
            check("sat_lo", sat_lo, e.lo);
        end
        if (upd === 1'b1) upd_seen++;
        if (pre == 0) acc = 0;
        if (pwm_out === 1'b1) acc++;
        if (pre == MAXV) last_hi = acc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(2'b00, 1'b0);
    endtask

    task automatic run_to(input int target);
        while (m_cnt != target) cycle(2'b00, 1'b0);
    endtask

    // Called at posedge+1; asserts reset asynchronously mid-cycle and releases it
    // just after a later edge so the next modelled edge is the first after release.
    task automatic apply_reset();
        #1;
        reset = 1'b1;
        dato  = 2'b01;
        #1;
        check("rst_pwm", pwm_out, 0);
        check("rst_duty", duty_out, 128);
        check("rst_upd", upd, 0);
        check("rst_sat", {sat_hi, sat_lo}, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clkm);
            #1;
            dato = (i == 1) ? 2'b10 : 2'b01;
            check("rst_hold_duty", duty_out, 128);
            check("rst_hold_pwm", pwm_out, 0);
        end
        #1;
        reset = 1'b0;
        dato  = 2'b00;
        m_cnt = 0;
        m_pend = 128;
        m_act  = 128;
        acc    = 0;
    endtask

    initial begin
        m_cnt = 0; m_pend = 128; m_act = 128;
        acc = 0; last_hi = -1; upd_seen = 0;

        @(posedge clkm);
        #1;
        apply_reset();

        // Idle after reset: half duty, no updates.
        upd_seen = 0;
        idle(512);
        check("idle_period_hi", last_hi, 128);
        check("idle_upd_cnt", upd_seen, 0);

        // Three fine increments mid-period, applied at the next boundary.
        upd_seen = 0;
        run_to(40);
        cycle(2'b01, 1'b0);
        cycle(2'b00, 1'b0);
        cycle(2'b01, 1'b0);
        cycle(2'b01, 1'b0);
        check("inc3_duty", duty_out, 131);
        run_to(0);
        check("inc3_old_period", last_hi, 128);
        idle(256);
        check("inc3_new_period", last_hi, 131);
        check("inc3_upd_cnt", upd_seen, 1);

        // Coarse increments saturate at the top.
        @(posedge clkm);
        #1;
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(2'b01, 1'b1);
        check("sat_hi_duty", duty_out, 255);
        check("sat_hi_flag", sat_hi, 1);
        cycle(2'b01, 1'b1);
        check("sat_hi_hold", duty_out, 255);
        run_to(0);
        idle(256);
        check("max_period_hi", last_hi, 255);

        // Coarse decrements saturate at zero; pwm stays low.
        @(posedge clkm);
        #1;
        apply_reset();
        for (int i = 0; i < 9; i++) cycle(2'b10, 1'b1);
        check("sat_lo_duty", duty_out, 0);
        check("sat_lo_flag", sat_lo, 1);
        run_to(0);
        idle(256);
        check("zero_period_hi", last_hi, 0);

        // dato=11 is a no-op; a pulse on the terminal count waits a full period.
        @(posedge clkm);
        #1;
        apply_reset();
        upd_seen = 0;
        run_to(100);
        cycle(2'b11, 1'b0);
        check("both_bits_duty", duty_out, 128);
        run_to(255);
        cycle(2'b01, 1'b0);
        check("tc_inc_duty", duty_out, 129);
        idle(256);
        check("tc_inc_first_period", last_hi, 128);
        idle(256);
        check("tc_inc_second_period", last_hi, 129);
        check("tc_inc_upd_cnt", upd_seen, 1);

        // Duty 200, then reset mid-period at cnt=50.
        @(posedge clkm);
        #1;
        apply_reset();
        for (int i = 0; i < 4; i++) cycle(2'b01, 1'b1);
        for (int i = 0; i < 8; i++) cycle(2'b01, 1'b0);
        check("duty200", duty_out, 200);
        run_to(0);
        run_to(50);
        check("pre_rst_pwm", pwm_out, 1);
        apply_reset();
        idle(256);
        check("post_rst_period_hi", last_hi, 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
